// File: rtl/lsu_mem_master.sv
// RV32I load/store initiator for a word-addressed data memory.
// Sequences aligned reads, whole-word writes and read-modify-write for SB/SH.
module lsu_mem_master #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_WE,
    output logic [31:0] mem_A,
    output logic [31:0] mem_WD,
    input  logic [31:0] mem_RD
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [31:0] MEM_LIM = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  f3_q, f3_d;
    logic        we_q, we_d;
    logic        err_q, err_d;
    logic        rdy_q;

    logic        accept;
    logic        f3_ok;
    logic        misal;
    logic        oor;
    logic        bad;
    logic [31:0] rd_sh_b;
    logic [31:0] rd_sh_h;
    logic [31:0] ld_ext;
    logic [31:0] wd_merge;

    assign req_ready = rdy_q && (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    always_comb begin
        f3_ok = 1'b0;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
                default:                f3_ok = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010,
                3'b100, 3'b101:         f3_ok = 1'b1;
                default:                f3_ok = 1'b0;
            endcase
        end
    end

    assign misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    assign oor   = {2'b00, req_addr[31:2]} >= MEM_LIM;
    assign bad   = !f3_ok || misal || oor;

    assign rd_sh_b = mem_RD >> {addr_q[1:0], 3'b000};
    assign rd_sh_h = mem_RD >> {addr_q[1], 4'b0000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{rd_sh_b[7]}}, rd_sh_b[7:0]};
            3'b001:  ld_ext = {{16{rd_sh_h[15]}}, rd_sh_h[15:0]};
            3'b100:  ld_ext = {24'h0, rd_sh_b[7:0]};
            3'b101:  ld_ext = {16'h0, rd_sh_h[15:0]};
            default: ld_ext = mem_RD;
        endcase
    end

    // Sub-word stores overlay the lane onto the word captured in READ.
    always_comb begin
        wd_merge = buf_q;
        case (f3_q[1:0])
            2'b00:   wd_merge[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
            2'b01:   wd_merge[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: wd_merge = wdata_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        buf_d   = buf_q;
        rdata_d = rdata_q;
        f3_d    = f3_q;
        we_d    = we_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    f3_d    = req_funct3;
                    we_d    = req_we;
                    rdata_d = 32'h0;
                    err_d   = bad;
                    if (bad) begin
                        state_d = RESP;
                    end else if (req_we && (req_funct3 == 3'b010)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    buf_d   = mem_RD;
                    state_d = WRITE;
                end else begin
                    rdata_d = ld_ext;
                    state_d = RESP;
                end
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            buf_q   <= 32'h0;
            rdata_q <= 32'h0;
            f3_q    <= 3'b000;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            buf_q   <= buf_d;
            rdata_q <= rdata_d;
            f3_q    <= f3_d;
            we_q    <= we_d;
            err_q   <= err_d;
            rdy_q   <= 1'b1;
        end
    end

    assign mem_WE     = (state_q == WRITE);
    assign mem_A      = ((state_q == READ) || (state_q == WRITE)) ?
                        {2'b00, addr_q[31:2]} : 32'h0;
    assign mem_WD     = (state_q == WRITE) ? wd_merge : 32'h0;
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
    assign resp_err   = (state_q == RESP) && err_q;

endmodule
